// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: R-type funct codes,
// the sequencer state encoding and small funct-decoding helpers.
package mips_pkg;

    // R-type funct field values for the HI/LO instruction group
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    // Sequencer states: idle, iterating, result-written pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // True for the four iterative ops
    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // True for the divide flavours
    function automatic logic is_div_funct(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    // True for the signed flavours
    function automatic logic is_signed_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Combinational post-processing of the unsigned magnitude result: restores
// signs for the signed ops and applies the divide-by-zero and signed
// overflow result rules.
module muldiv_sign_fixup #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_raw_hi,    // product upper half or remainder magnitude
    input  logic [DATA_W-1:0] i_raw_lo,    // product lower half or quotient magnitude
    input  logic              i_is_div,
    input  logic              i_neg_a,     // rs was negative in a signed op
    input  logic              i_neg_b,     // rt was negative in a signed op
    input  logic              i_div_zero,
    input  logic              i_overflow,  // signed most-negative / -1
    input  logic [DATA_W-1:0] i_rs_orig,   // untouched rs, returned in HI on divide by zero
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_neg;
    logic [DATA_W-1:0]   w_quot_neg;
    logic [DATA_W-1:0]   w_rem_neg;
    logic                w_res_neg;

    assign w_prod     = {i_raw_hi, i_raw_lo};
    assign w_prod_neg = -w_prod;
    assign w_quot_neg = -i_raw_lo;
    assign w_rem_neg  = -i_raw_hi;
    assign w_res_neg  = i_neg_a ^ i_neg_b;

    // Select the final HI/LO pair from the magnitude result and the special cases
    always_comb begin
        o_hi = i_raw_hi;
        o_lo = i_raw_lo;
        if (i_is_div) begin
            if (i_div_zero) begin
                o_hi = i_rs_orig;
                o_lo = '1;
            end else if (i_overflow) begin
                o_hi = '0;
                o_lo = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                // quotient truncates toward zero, remainder follows the dividend
                o_lo = w_res_neg ? w_quot_neg : i_raw_lo;
                o_hi = i_neg_a   ? w_rem_neg  : i_raw_hi;
            end
        end else if (w_res_neg) begin
            o_hi = w_prod_neg[2*DATA_W-1:DATA_W];
            o_lo = w_prod_neg[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: iterative multiply/divide (one bit per cycle over operand
// magnitudes) plus direct MTHI/MTLO writes. HI/LO are presented continuously.
//
// Handshake: start is a one-cycle request strobe qualified by functcode; it is
// taken on a rising edge only when busy is low (IDLE or DONE). A request seen
// while busy, or with a funct outside the HI/LO group, is dropped with no side
// effect, so busy acts as the inverse of ready. done pulses for one cycle when
// a multiply/divide result lands in HI/LO.
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        functcode,
    input  logic [DATA_W-1:0] rs_content,
    input  logic [DATA_W-1:0] rt_content,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output muldiv_state_t     o_dbg_state
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    muldiv_state_t       r_state;
    muldiv_state_t       w_next_state;
    logic [CNT_W-1:0]    r_cnt;

    // r_p holds {upper, lower}: product accumulator for multiply,
    // {remainder, quotient/dividend} for divide.
    logic [2*DATA_W-1:0] r_p;
    logic [DATA_W-1:0]   r_m;          // multiplicand or divisor magnitude
    logic                r_is_div;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_div_zero;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_rs_orig;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_can_accept;
    logic                w_accept_md;
    logic                w_accept_mthi;
    logic                w_accept_mtlo;
    logic                w_last;
    logic                w_signed_op;
    logic                w_div_op;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [DATA_W-1:0]   w_rs_mag;
    logic [DATA_W-1:0]   w_rt_mag;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [DATA_W:0]     w_div_shift;
    logic                w_div_ge;
    logic [DATA_W-1:0]   w_div_diff;
    logic [DATA_W-1:0]   w_div_rem;
    logic [2*DATA_W-1:0] w_div_next;
    logic [2*DATA_W-1:0] w_step;
    logic [DATA_W-1:0]   w_fix_hi;
    logic [DATA_W-1:0]   w_fix_lo;

    // Request qualification
    assign w_can_accept  = (r_state != CALC);
    assign w_accept_md   = start && w_can_accept && is_muldiv_funct(functcode);
    assign w_accept_mthi = start && w_can_accept && (functcode == FUNCT_MTHI);
    assign w_accept_mtlo = start && w_can_accept && (functcode == FUNCT_MTLO);
    assign w_last        = (r_state == CALC) && (r_cnt == CNT_LAST);

    // Operand magnitudes and signs at the accepting edge
    assign w_signed_op = is_signed_funct(functcode);
    assign w_div_op    = is_div_funct(functcode);
    assign w_rs_neg    = w_signed_op && rs_content[DATA_W-1];
    assign w_rt_neg    = w_signed_op && rt_content[DATA_W-1];
    assign w_rs_mag    = w_rs_neg ? -rs_content : rs_content;
    assign w_rt_mag    = w_rt_neg ? -rt_content : rt_content;

    // Multiply step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {upper, lower} pair right by one.
    assign w_mul_sum  = {1'b0, r_p[2*DATA_W-1:DATA_W]} +
                        (r_p[0] ? {1'b0, r_m} : {(DATA_W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_p[DATA_W-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the outcome into the quotient.
    // The remainder stays below the divisor, so a DATA_W-bit difference is exact.
    assign w_div_shift = r_p[2*DATA_W-1:DATA_W-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_m});
    assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_m;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[DATA_W-1:0];
    assign w_div_next  = {w_div_rem, r_p[DATA_W-2:0], w_div_ge};

    assign w_step = r_is_div ? w_div_next : w_mul_next;

    // Final result is formed from the last step so HI/LO update on the last edge
    muldiv_sign_fixup #(
        .DATA_W (DATA_W)
    ) u_fixup (
        .i_raw_hi   (w_step[2*DATA_W-1:DATA_W]),
        .i_raw_lo   (w_step[DATA_W-1:0]),
        .i_is_div   (r_is_div),
        .i_neg_a    (r_neg_a),
        .i_neg_b    (r_neg_b),
        .i_div_zero (r_div_zero),
        .i_overflow (r_overflow),
        .i_rs_orig  (r_rs_orig),
        .o_hi       (w_fix_hi),
        .o_lo       (w_fix_lo)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept_md) w_next_state = CALC;
            CALC:    if (r_cnt == CNT_LAST) w_next_state = DONE;
            DONE:    w_next_state = w_accept_md ? CALC : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy        = (r_state == CALC);
        done        = (r_state == DONE);
        o_dbg_state = r_state;
    end

    // Iteration counter, restarted on every accepted multiply/divide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept_md) begin
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p        <= '0;
            r_m        <= '0;
            r_is_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
            r_rs_orig  <= '0;
        end else if (w_accept_md) begin
            r_is_div   <= w_div_op;
            r_neg_a    <= w_rs_neg;
            r_neg_b    <= w_rt_neg;
            r_div_zero <= w_div_op && (rt_content == '0);
            r_overflow <= w_div_op && w_signed_op &&
                          (rs_content == {1'b1, {(DATA_W-1){1'b0}}}) &&
                          (rt_content == '1);
            r_rs_orig  <= rs_content;
            if (w_div_op) begin
                r_p <= {{DATA_W{1'b0}}, w_rs_mag};
                r_m <= w_rt_mag;
            end else begin
                r_p <= {{DATA_W{1'b0}}, w_rt_mag};
                r_m <= w_rs_mag;
            end
        end else if (r_state == CALC) begin
            r_p <= w_step;
        end
    end

    // Architectural HI/LO: written by a finishing op or by MTHI/MTLO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else begin
            if (w_accept_mthi) r_hi <= rs_content;
            if (w_accept_mtlo) r_lo <= rs_content;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus random
// ops checked against an arithmetic reference model and an expected queue.
module tb_hilo_muldiv_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [5:0]    functcode;
    logic [W-1:0]  rs_content;
    logic [W-1:0]  rt_content;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    muldiv_state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;

    hilo_muldiv_unit #(
        .DATA_W (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .functcode   (functcode),
        .rs_content  (rs_content),
        .rt_content  (rt_content),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end (got timeout, want finish)");
        $fatal(1);
    end

    // reference model: plain 64-bit arithmetic, {hi, lo}
    function automatic logic [2*W-1:0] ref_result(input logic [5:0] f,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint         sa, sb, q, r;
        logic [2*W-1:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (f)
            FUNCT_MULTU: res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            FUNCT_MULT:  res = sa * sb;
            FUNCT_DIVU: begin
                if (b == 0) res = {a, {W{1'b1}}};
                else        res = {a % b, a / b};
            end
            FUNCT_DIV: begin
                if (b == 0) res = {a, {W{1'b1}}};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[W-1:0], q[W-1:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic check_val(input string tag, input logic [2*W-1:0] got,
                             input logic [2*W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // driver: accepted request (caller ensures the unit is not busy)
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        start      = 1'b1;
        functcode  = f;
        rs_content = a;
        rt_content = b;
        if (is_muldiv_funct(f)) exp_q.push_back(ref_result(f, a, b));
        if (f == FUNCT_MTHI) m_hi = a;
        if (f == FUNCT_MTLO) m_lo = a;
        @(negedge clk);
        start      = 1'b0;
        functcode  = 6'($urandom_range(0, 63));
        rs_content = $urandom;
        rt_content = $urandom;
        if (f == FUNCT_MTHI) begin
            check_val("mthi_hi", hi, m_hi);
            check_val("mthi_done", done, 0);
        end
        if (f == FUNCT_MTLO) begin
            check_val("mtlo_lo", lo, m_lo);
            check_val("mtlo_done", done, 0);
        end
    endtask

    // driver: request that the unit must ignore
    task automatic poke(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        start      = 1'b1;
        functcode  = f;
        rs_content = a;
        rt_content = b;
        @(negedge clk);
        start      = 1'b0;
        rs_content = $urandom;
        rt_content = $urandom;
    endtask

    // scoreboard: wait for done, count busy cycles, compare against exp_q
    task automatic wait_done(input int exp_busy);
        int             n;
        int             busy_cnt;
        logic [2*W-1:0] e;
        n        = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) busy_cnt++;
            if (n == 10) check_val("hold_hilo", {hi, lo}, {m_hi, m_lo});
            @(negedge clk);
            n++;
        end
        check_val("done_seen", done, 1);
        check_val("busy_at_done", busy, 0);
        check_val("busy_cycles", busy_cnt, exp_busy);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            {m_hi, m_lo} = e;
        end
        check_val("res_hi", hi, m_hi);
        check_val("res_lo", lo, m_lo);
    endtask

    task automatic check_quiet();
        @(negedge clk);
        check_val("done_drop", done, 0);
        check_val("idle_busy", busy, 0);
    endtask

    logic [5:0] ops [6];

    initial begin
        ops = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};
        reset      = 1'b1;
        start      = 1'b0;
        functcode  = '0;
        rs_content = '0;
        rt_content = '0;
        m_hi       = '0;
        m_lo       = '0;
        repeat (2) @(negedge clk);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_state", dbg_state, IDLE);
        reset = 1'b0;
        @(negedge clk);

        // full-width unsigned multiply
        issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(32);
        check_quiet();

        // signed multiply, then divide issued in the DONE cycle
        issue(FUNCT_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(32);
        issue(FUNCT_DIVU, 32'd7, 32'd2);
        wait_done(32);
        check_quiet();

        // signed divide and signed overflow back to back
        issue(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(32);
        issue(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(32);
        check_quiet();

        // divide by zero
        issue(FUNCT_DIV, 32'h12345678, 32'd0);
        wait_done(32);
        check_quiet();

        // MTHI, then requests during busy must be ignored
        issue(FUNCT_MTHI, 32'hDEADBEEF, 32'd0);
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        poke(FUNCT_MTLO, 32'd1, 32'd0);
        poke(FUNCT_MULTU, 32'd5, 32'd5);
        wait_done(30);
        check_quiet();

        // asynchronous reset in the middle of a divide
        issue(FUNCT_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_hi", hi, 0);
        check_val("midrst_lo", lo, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        issue(FUNCT_MULTU, 32'd3, 32'd5);
        wait_done(32);
        check_quiet();

        // randomized ops with corner operands, sometimes back to back
        for (int i = 0; i < 24; i++) begin
            logic [5:0]   f;
            logic [W-1:0] a, b;
            f = ops[$urandom_range(0, 5)];
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = 32'h80000000;
                2:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(f, a, b);
            if (is_muldiv_funct(f)) begin
                wait_done(32);
                if ($urandom_range(0, 1) == 0) @(negedge clk);
            end
        end
        @(negedge clk);
        check_val("final_hi", hi, m_hi);
        check_val("final_lo", lo, m_lo);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
